pkt_rr_mux: RTL and testbench
=============================

Name: pkt_rr_mux

Overview:
- Round-robin packet multiplexer: N valid/ready input streams merge onto one output stream.
- Arbitration is packet-locked. Once a requester wins, it keeps the output until its beat with in_last is accepted. The round-robin pointer then moves to the requester after the winner.
- Sits on the consumer side of request/grant arbitration. It turns one-hot grants into a data path feeding a shared downstream sink.

Parameters:
- N, 5, number of input streams (N >= 2)
- W, 8, data width per beat

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  N  per-stream beat valid
- in_data  input  N*W  stream i occupies bits [i*W +: W]
- in_last  input  N  per-stream last beat of packet
- in_ready  output  N  per-stream accept; at most one bit set
- out_valid  output  1  output beat valid (registered)
- out_data  output  W  output beat data (registered)
- out_last  output  1  output last flag (registered)
- out_ready  input  1  downstream accept
- owner  output  N  one-hot current lock holder; 0 when idle
- busy  output  1  1 while in LOCK state

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, out_data=0, out_last=0, owner=0, busy=0, state=IDLE.
  - pointer=one-hot 1 (stream 0 highest priority).
- Pick function:
  - Search in_valid starting at the pointer bit, ascending, wrapping N-1 to 0.
  - Returns a one-hot bit, or 0 if no valid.
- State IDLE:
  - in_ready=0.
  - If any in_valid, then next edge: owner<=pick, busy<=1, state<=LOCK.
  - One-cycle arbitration bubble per packet; this is intended.
- State LOCK:
  - in_ready = owner & {N{load}}, where load = !out_valid || out_ready.
  - Accept when in_valid[k] && in_ready[k]: out_data<=in_data[k], out_last<=in_last[k], out_valid<=1.
  - If load is true and no beat is accepted, out_valid<=0.
  - Accept with in_last=1: state<=IDLE, owner<=0, busy<=0, pointer<=owner rotated left by 1 (bit N-1 wraps to bit 0).
- Output register:
  - Latency is exactly 1 cycle from input accept to out_valid.
  - Throughput is 1 beat/cycle within a packet.
  - While out_valid && !out_ready, out_data and out_last stay stable and in_ready=0.
- Owner source stalls: if in_valid[owner] drops mid-packet, the lock is held and other streams wait. No timeout.
- Single-beat packets are legal (in_last on the first beat).
- The pointer changes only at packet end, never on stalls or idle cycles.
- Inputs of non-owner streams are ignored. in_ready stays 0 for them.
- Reset mid-packet: the partial packet is dropped and all state returns to reset values. Downstream sees out_valid fall asynchronously.
- Sources must hold in_valid and data until accepted. The block does not check this.

Decomposition:
- Package pkt_rr_mux_pkg:
  - state enum {IDLE, LOCK}
  - function rotl1(one-hot, N) for the pointer update
- Sub-module rr_pick: combinational, parameter N.
  - Inputs req[N] and pointer[N]; output pick[N].
  - Uses the double-width subtract-and-mask trick.
  - No state; unit-tested alone.

Test Plan:
- Async reset: assert rst mid-packet between clock edges. out_valid=0, owner=0 and busy=0 immediately. After release, the first grant goes to the lowest-index valid stream.
- Fairness, N=5: all streams send endless 1-beat packets with data 8'h10+i, out_ready=1. out_data sequence is 10,11,12,13,14,10,... with one beat per 2 cycles.
- Packet lock: stream 2 sends 3 beats A0,A1,A2 (last on A2) while stream 0 is valid. Output is A0,A1,A2 on consecutive cycles with owner=5'b00100, then stream 0's beat.
- Backpressure: hold out_ready=0 for 3 cycles while out_valid=1 mid-packet. out_data is unchanged, in_ready=0, and no beat is lost or duplicated after release.
- Wrap-around: only streams 4 and 0 active. After stream 4's packet, pointer=5'b00001 and stream 0 wins next. After that, stream 4 wins.
- Source stall: stream 1 drops in_valid for 2 cycles mid-packet while stream 3 is valid. owner stays 5'b00010, out_valid goes 0 for those cycles, and stream 3 is not served until stream 1's last beat.

Source files
------------

// File: rtl/pkt_rr_mux_pkg.sv
// pkt_rr_mux_pkg: shared types and helpers for the round-robin packet multiplexer
//   state_t : arbiter state (IDLE waiting for a request, LOCK while a packet is in flight)
//   rotl1   : rotate the low n bits of a one-hot vector left by one, bit n-1 wrapping to bit 0
package pkt_rr_mux_pkg;

    typedef enum logic {IDLE, LOCK} state_t;

    localparam int MAX_N = 32;

    function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
        logic [MAX_N-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_N; i++)
            if (i < n) r[5'((i + 1) % n)] = v[5'(i)];
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin pick, first set request at or above the pointer, wrapping
//   req_i  [N] : request vector
//   ptr_i  [N] : one-hot highest-priority position
//   pick_o [N] : one-hot winner, 0 when no request
module rr_pick #(
    parameter int N = 5
) (
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] ptr_i,
    output logic [N-1:0] pick_o
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] gnt;

    // Subtracting the pointer from the doubled request clears the lowest request at or
    // above the pointer and sets the bits below it; masking keeps only that request.
    // The upper copy catches the wrap-around case.
    assign dbl    = {req_i, req_i};
    assign gnt    = dbl & ~(dbl - {{N{1'b0}}, ptr_i});
    assign pick_o = gnt[N-1:0] | gnt[2*N-1:N];

endmodule

// File: rtl/pkt_rr_mux.sv
// pkt_rr_mux: packet-locked round-robin merge of N valid/ready streams onto one registered output
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid_i/last_i[N] : per-stream beat valid and last-beat flag
//   in_data_i [N*W]      : stream i in bits [i*W +: W]
//   in_ready_o[N]        : per-stream accept, only ever the owner's bit
//   out_valid_o/data_o/last_o : registered output beat, out_ready_i accepts it
//   owner_o [N]          : one-hot lock holder, 0 when idle
//   busy_o               : high while a packet holds the lock
module pkt_rr_mux
    import pkt_rr_mux_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid_i,
    input  logic [N*W-1:0] in_data_i,
    input  logic [N-1:0]   in_last_i,
    output logic [N-1:0]   in_ready_o,
    output logic           out_valid_o,
    output logic [W-1:0]   out_data_o,
    output logic           out_last_o,
    input  logic           out_ready_i,
    output logic [N-1:0]   owner_o,
    output logic           busy_o
);

    state_t         state_q, state_d;
    logic [N-1:0]   owner_q, owner_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic           busy_q, busy_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic [N-1:0]   pick;
    logic           load;
    logic           acc;
    logic [W-1:0]   sel_data;
    logic           sel_last;
    logic [MAX_N-1:0] ptr_rot;

    rr_pick #(.N(N)) u_pick (
        .req_i  (in_valid_i),
        .ptr_i  (ptr_q),
        .pick_o (pick)
    );

    // The output register can take a new beat when empty or being drained this cycle.
    assign load       = !out_valid_q || out_ready_i;
    assign in_ready_o = (state_q == LOCK) ? (owner_q & {N{load}}) : '0;
    assign acc        = |(in_valid_i & in_ready_o);
    assign ptr_rot    = rotl1(MAX_N'(owner_q), N);

    always_comb begin
        sel_data = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (owner_q[i]) begin
                sel_data = in_data_i[i*W +: W];
                sel_last = in_last_i[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;
        out_valid_d = acc ? 1'b1 : (load ? 1'b0 : out_valid_q);
        out_data_d  = acc ? sel_data : out_data_q;
        out_last_d  = acc ? sel_last : out_last_q;
        if (state_q == IDLE) begin
            if (|in_valid_i) begin
                state_d = LOCK;
                owner_d = pick;
                busy_d  = 1'b1;
            end
        end else if (acc && sel_last) begin
            state_d = IDLE;
            owner_d = '0;
            busy_d  = 1'b0;
            ptr_d   = ptr_rot[N-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= N'(1);
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign owner_o     = owner_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pkt_rr_mux.sv
// tb_pkt_rr_mux: randomized and directed check of pkt_rr_mux against a stream-level reference model
module tb_pkt_rr_mux;

    localparam int N = 5;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   in_valid_i;
    logic [N*W-1:0] in_data_i;
    logic [N-1:0]   in_last_i;
    logic [N-1:0]   in_ready_o;
    logic           out_valid_o;
    logic [W-1:0]   out_data_o;
    logic           out_last_o;
    logic           out_ready_i;
    logic [N-1:0]   owner_o;
    logic           busy_o;

    always #5 clk = ~clk;

    pkt_rr_mux #(.N(N), .W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid_i),
        .in_data_i   (in_data_i),
        .in_last_i   (in_last_i),
        .in_ready_o  (in_ready_o),
        .out_valid_o (out_valid_o),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .out_ready_i (out_ready_i),
        .owner_o     (owner_o),
        .busy_o      (busy_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Source side: per-stream packet queues of {last, data}; a beat once offered is held.
    logic [8:0] sq[N][$];
    bit         offered[N];
    int         stall_pct;
    int         rdy_pct;
    logic [7:0] seen[$];
    bit         record;

    // Reference model: lock holder as an index, priority start as an index.
    bit         m_busy;
    int         m_own;
    int         m_ptr;
    bit         m_ov;
    bit         m_ol;
    logic [7:0] m_od;

    task automatic model_reset();
        m_busy = 0; m_own = -1; m_ptr = 0; m_ov = 0; m_ol = 0; m_od = '0;
        for (int i = 0; i < N; i++) begin
            sq[i].delete();
            offered[i] = 0;
        end
    endtask

    function automatic bit pending();
        bit p = m_busy || m_ov;
        for (int i = 0; i < N; i++) if (sq[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic cycle();
        logic [8:0]   head;
        logic [N-1:0] exp_rdy;
        logic [N-1:0] exp_own;
        bit           ld;
        int           w;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!offered[i] && sq[i].size() > 0 && $urandom_range(99) >= stall_pct) offered[i] = 1;
            head = offered[i] ? sq[i][0] : 9'($urandom);
            in_valid_i[i]        = offered[i];
            in_data_i[i*W +: W]  = head[7:0];
            in_last_i[i]         = head[8];
        end
        out_ready_i = ($urandom_range(99) < rdy_pct);
        #1;
        ld      = !m_ov || out_ready_i;
        exp_rdy = (m_busy && ld) ? (N'(1) << m_own) : '0;
        exp_own = m_busy ? (N'(1) << m_own) : '0;
        chk("in_ready", 32'(in_ready_o), 32'(exp_rdy));
        chk("owner", 32'(owner_o), 32'(exp_own));
        chk("busy", 32'(busy_o), 32'(m_busy));
        chk("out_valid", 32'(out_valid_o), 32'(m_ov));
        if (m_ov) begin
            chk("out_data", 32'(out_data_o), 32'(m_od));
            chk("out_last", 32'(out_last_o), 32'(m_ol));
        end
        if (record && out_valid_o && out_ready_i) seen.push_back(out_data_o);
        if (!m_busy) begin
            if (ld) m_ov = 0;
            w = -1;
            for (int j = 0; j < N; j++) if (w < 0 && offered[(m_ptr + j) % N]) w = (m_ptr + j) % N;
            if (w >= 0) begin
                m_busy = 1;
                m_own  = w;
            end
        end else if (ld && offered[m_own]) begin
            head = sq[m_own].pop_front();
            offered[m_own] = 0;
            m_ov = 1; m_od = head[7:0]; m_ol = head[8];
            if (head[8]) begin
                m_busy = 0;
                m_ptr  = (m_own + 1) % N;
                m_own  = -1;
            end
        end else if (ld) begin
            m_ov = 0;
        end
        @(posedge clk);
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (pending() && c < budget) begin
            cycle();
            c++;
        end
        if (c >= budget) chk("drain_timeout", 32'(c), 32'(budget - 1));
    endtask

    task automatic push_pkt(input int s, input int len);
        for (int b = 0; b < len; b++) sq[s].push_back({b == len - 1, 8'($urandom)});
    endtask

    initial begin
        rst = 1'b1; in_valid_i = '0; in_data_i = '0; in_last_i = '0; out_ready_i = 1'b0;
        record = 0; stall_pct = 0; rdy_pct = 100;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid_o), 0);
        chk("rst_out_data", 32'(out_data_o), 0);
        chk("rst_out_last", 32'(out_last_o), 0);
        chk("rst_owner", 32'(owner_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst = 1'b0;

        // Fairness: every stream has endless single-beat packets.
        for (int i = 0; i < N; i++) repeat (8) sq[i].push_back({1'b1, 8'(8'h10 + i)});
        seen.delete(); record = 1;
        drain(200);
        chk("fair_count", 32'(seen.size()), 40);
        for (int i = 0; i < 10 && i < seen.size(); i++) chk("fair_seq", 32'(seen[i]), 32'(8'h10 + i % N));

        // Packet lock: stream 2 wins, stream 0 arrives and waits for A2.
        seen.delete();
        sq[2].push_back(9'h0A0); sq[2].push_back(9'h0A1); sq[2].push_back(9'h1A2);
        cycle();
        sq[0].push_back(9'h155);
        drain(50);
        chk("lock_count", 32'(seen.size()), 4);
        if (seen.size() == 4) begin
            chk("lock_0", 32'(seen[0]), 32'hA0);
            chk("lock_1", 32'(seen[1]), 32'hA1);
            chk("lock_2", 32'(seen[2]), 32'hA2);
            chk("lock_3", 32'(seen[3]), 32'h55);
        end

        // Wrap-around: priority now at stream 1, so 4 then 0 then 4 then 0.
        seen.delete();
        sq[4].push_back(9'h140); sq[4].push_back(9'h141);
        sq[0].push_back(9'h100); sq[0].push_back(9'h101);
        drain(50);
        chk("wrap_count", 32'(seen.size()), 4);
        if (seen.size() == 4) begin
            chk("wrap_0", 32'(seen[0]), 32'h40);
            chk("wrap_1", 32'(seen[1]), 32'h00);
            chk("wrap_2", 32'(seen[2]), 32'h41);
            chk("wrap_3", 32'(seen[3]), 32'h01);
        end

        // Random traffic with source stalls and downstream backpressure.
        record = 0; stall_pct = 30; rdy_pct = 60;
        for (int p = 0; p < 60; p++) push_pkt($urandom_range(N - 1), $urandom_range(1, 4));
        drain(5000);

        // Heavy backpressure with long packets.
        rdy_pct = 25; stall_pct = 10;
        for (int i = 0; i < N; i++) push_pkt(i, 5);
        drain(3000);

        // Asynchronous reset in the middle of a packet.
        stall_pct = 0; rdy_pct = 100;
        push_pkt(1, 6);
        push_pkt(3, 1);
        repeat (4) cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid_o), 0);
        chk("arst_owner", 32'(owner_o), 0);
        chk("arst_busy", 32'(busy_o), 0);
        model_reset();
        in_valid_i = '0;
        @(negedge clk);
        rst = 1'b0;
        push_pkt(3, 1);
        push_pkt(2, 1);
        cycle();
        #1;
        chk("first_grant", 32'(owner_o), 32'h04);
        drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
